// File: rtl/serial_alu_if.sv
// Requester-side bundle for serial_alu: start/busy/done handshake, operands and result flags.
interface serial_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] x;
  logic             c_out;
  logic             zero;

  modport master (
    output start, mode, a, b, c_in,
    input  busy, done, x, c_out, zero
  );

  modport slave (
    input  start, mode, a, b, c_in,
    output busy, done, x, c_out, zero
  );
endinterface

// File: rtl/serial_alu.sv
// Digit-serial ALU: LSB-first, DIGIT bits per clock through a registered carry.
// Result bits shift into the top of the A register as operand bits leave the bottom.
module serial_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_alu_if.slave  bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [2:0] {
    ModeAdd  = 3'd0,
    ModeAnd  = 3'd1,
    ModeOr   = 3'd2,
    ModeXor  = 3'd3,
    ModeXnor = 3'd4,
    ModeSub  = 3'd5
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;

  logic [WIDTH+DIGIT-1:0] a_cat;
  logic [DIGIT-1:0]       a_sl, b_sl, r_sl;
  logic [DIGIT:0]         sum;
  logic                   carry_nxt;
  logic [WIDTH-1:0]       a_nxt;
  logic                   carry_init;
  logic                   last;

  // One slice of the datapath; reserved modes produce zero and kill the carry.
  always_comb begin
    a_cat     = {r_sl, a_q};
    a_sl      = a_cat[DIGIT-1:0];
    b_sl      = (mode_q == ModeSub) ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    sum       = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
    r_sl      = '0;
    carry_nxt = 1'b0;
    unique case (mode_q)
      ModeAdd, ModeSub: begin
        r_sl      = sum[DIGIT-1:0];
        carry_nxt = sum[DIGIT];
      end
      ModeAnd:  r_sl = a_sl & b_sl;
      ModeOr:   r_sl = a_sl | b_sl;
      ModeXor:  r_sl = a_sl ^ b_sl;
      ModeXnor: r_sl = ~(a_sl ^ b_sl);
      default:  r_sl = '0;
    endcase
  end

  assign a_nxt = a_cat[WIDTH+DIGIT-1:DIGIT];
  assign last  = (cnt_q == CntW'(N - 1));

  always_comb begin
    unique case (mode_e'(bus.mode))
      ModeAdd: carry_init = bus.c_in;
      ModeSub: carry_init = 1'b1;
      default: carry_init = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    c_out_d = c_out_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StRun;
          mode_d  = mode_e'(bus.mode);
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = carry_init;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d     = a_nxt;
        b_d     = b_q >> DIGIT;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          x_d     = a_nxt;
          c_out_d = carry_nxt;
          zero_d  = (a_nxt == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeAdd;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      c_out_q <= c_out_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.x     = x_q;
  assign bus.c_out = c_out_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: a DIGIT=1 and a DIGIT=4 instance, directed vectors.
module tb_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  serial_alu_if #(.WIDTH(8)) bus1 ();
  serial_alu_if #(.WIDTH(8)) bus4 ();

  serial_alu #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_alu #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [7:0]  x;
    logic        c;
    logic        z;
    int unsigned t0;
  } exp_t;

  exp_t        q1[$];
  exp_t        q4[$];
  int unsigned done_last1 = 0;
  int unsigned done_prev1 = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the DIGIT=1 instance (N=8).
  initial begin
    exp_t       e;
    logic [7:0] held;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
      end else if (bus1.done) begin
        check("busy_low_in_done1", {31'b0, bus1.busy}, 0);
        check("done_expected1", {31'b0, q1.size() != 0}, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("x1", {24'b0, bus1.x}, {24'b0, e.x});
          check("c_out1", {31'b0, bus1.c_out}, {31'b0, e.c});
          check("zero1", {31'b0, bus1.zero}, {31'b0, e.z});
          check("latency1", cyc - e.t0, 8);
        end
        held       = bus1.x;
        done_prev1 = done_last1;
        done_last1 = cyc;
      end else begin
        check("x_held1", {24'b0, bus1.x}, {24'b0, held});
      end
    end
  end

  // Monitor for the DIGIT=4 instance (N=2).
  initial begin
    exp_t       e;
    logic [7:0] held;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
      end else if (bus4.done) begin
        check("done_expected4", {31'b0, q4.size() != 0}, 1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          check("x4", {24'b0, bus4.x}, {24'b0, e.x});
          check("c_out4", {31'b0, bus4.c_out}, {31'b0, e.c});
          check("zero4", {31'b0, bus4.zero}, {31'b0, e.z});
          check("latency4", cyc - e.t0, 2);
        end
        held = bus4.x;
      end else begin
        check("x_held4", {24'b0, bus4.x}, {24'b0, held});
      end
    end
  end

  task automatic set_in(input int inst, input logic s, input logic [2:0] m,
                        input logic [7:0] a, input logic [7:0] b, input logic ci);
    if (inst == 4) begin
      bus4.start = s; bus4.mode = m; bus4.a = a; bus4.b = b; bus4.c_in = ci;
    end else begin
      bus1.start = s; bus1.mode = m; bus1.a = a; bus1.b = b; bus1.c_in = ci;
    end
  endtask

  // Operands are scrambled after the start drops to show RUN ignores them.
  task automatic issue(input int inst, input bit sync, input int hold, input logic [2:0] m,
                       input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] ex, input logic ec, input logic ez);
    exp_t e;
    if (sync) @(negedge clk);
    set_in(inst, 1'b1, m, a, b, ci);
    @(posedge clk);
    #1;
    e.x = ex; e.c = ec; e.z = ez; e.t0 = cyc;
    if (inst == 4) q4.push_back(e);
    else q1.push_back(e);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    set_in(inst, 1'b0, 3'd7, ~a, ~b, ~ci);
  endtask

  task automatic wait_done(input int inst);
    int n = 0;
    while (!((inst == 4) ? bus4.done : bus1.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", {31'b0, (inst == 4) ? bus4.done : bus1.done}, 1);
  endtask

  task automatic run(input int inst, input logic [2:0] m, input logic [7:0] a,
                     input logic [7:0] b, input logic ci,
                     input logic [7:0] ex, input logic ec, input logic ez);
    issue(inst, 1'b1, 0, m, a, b, ci, ex, ec, ez);
    wait_done(inst);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'b0, bus1.busy},  0);
    check({tag, "_done"},  {31'b0, bus1.done},  0);
    check({tag, "_x"},     {24'b0, bus1.x},     0);
    check({tag, "_c_out"}, {31'b0, bus1.c_out}, 0);
    check({tag, "_zero"},  {31'b0, bus1.zero},  0);
    check({tag, "_busy4"}, {31'b0, bus4.busy},  0);
    check({tag, "_x4"},    {24'b0, bus4.x},     0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    set_in(4, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // ADD / SUB / logic / reserved on the bit-serial instance.
    run(1, 3'd0, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0);
    run(1, 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    run(1, 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);
    run(1, 3'd5, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b1);
    run(1, 3'd5, 8'h03, 8'h04, 1'b1, 8'hFF, 1'b0, 1'b0);
    run(1, 3'd5, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, 1'b0);
    run(1, 3'd1, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0);
    run(1, 3'd2, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, 1'b0);
    run(1, 3'd3, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0);
    run(1, 3'd4, 8'hAA, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
    run(1, 3'd6, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
    run(1, 3'd7, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1);

    // start held through RUN: a second done would find the queue empty.
    issue(1, 1'b1, 8, 3'd0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    wait_done(1);
    repeat (12) @(negedge clk);

    // Back-to-back: second start presented in the DONE cycle.
    run(1, 3'd3, 8'h0F, 8'hFF, 1'b0, 8'hF0, 1'b0, 1'b0);
    issue(1, 1'b0, 0, 3'd5, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);
    wait_done(1);
    check("b2b_gap", done_last1 - done_prev1, 9);

    // Abort in RUN cycle 4 via an asynchronous reset between edges.
    issue(1, 1'b1, 0, 3'd0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("busy_before_abort", {31'b0, bus1.busy}, 1);
    check("x_before_abort", {24'b0, bus1.x}, 8'hFF);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    run(1, 3'd0, 8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b1);

    // Nibble-serial instance.
    run(4, 3'd1, 8'hC3, 8'hA5, 1'b1, 8'h81, 1'b0, 1'b0);
    run(4, 3'd2, 8'hC3, 8'hA5, 1'b1, 8'hE7, 1'b0, 1'b0);
    run(4, 3'd3, 8'hC3, 8'hA5, 1'b0, 8'h66, 1'b0, 1'b0);
    run(4, 3'd4, 8'hC3, 8'hA5, 1'b0, 8'h99, 1'b0, 1'b0);
    run(4, 3'd0, 8'h8F, 8'h71, 1'b0, 8'h00, 1'b1, 1'b1);
    run(4, 3'd5, 8'h20, 8'h21, 1'b0, 8'hFF, 1'b0, 1'b0);
    run(4, 3'd7, 8'hC3, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
